// File: rtl/uart_sram_loader_if.sv
// SRAM port-0 signal bundle between the UART loader (master) and the SRAM/mux (slave).
`timescale 1ns/1ps
interface uart_sram_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WMASKS = 4
);
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;

  modport master (output csb0, output web0, output wmask0, output addr0, output din0);
  modport slave  (input  csb0, input  web0, input  wmask0, input  addr0, input  din0);
endinterface

// File: rtl/uart_sram_loader.sv
// 8N1 UART program loader: packs little-endian bytes into words, writes SRAM port 0,
// and holds the core in reset until the announced word count has been written.
`timescale 1ns/1ps
module uart_sram_loader #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_WMASKS   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bypass,
  input  logic                uart_rx,
  uart_sram_loader_if.master  sram,
  output logic                core_rst,
  output logic                load_done,
  output logic                frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {S_CNT, S_DATA, S_WRITE, S_DONE} ld_state_e;

  // ---------------- UART receiver ----------------
  logic             sync1_q, sync2_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             bv_q, bv_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      bv_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      bv_q       <= bv_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    bv_d       = 1'b0;
    ferr_d     = ferr_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d      = '0;
          bit_d      = '0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
          else               bit_d      = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          if (sync2_q) bv_d   = 1'b1;
          else         ferr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Loader FSM ----------------
  ld_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [ADDR_WIDTH:0]   widx_q, widx_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  csb0_q, csb0_d, web0_q, web0_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  core_rst_q, core_rst_d, done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CNT;
      word_q     <= '0;
      bidx_q     <= '0;
      widx_q     <= '0;
      count_q    <= '0;
      csb0_q     <= 1'b1;
      web0_q     <= 1'b1;
      wmask_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bidx_q     <= bidx_d;
      widx_q     <= widx_d;
      count_q    <= count_d;
      csb0_q     <= csb0_d;
      web0_q     <= web0_d;
      wmask_q    <= wmask_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bidx_d  = bidx_q;
    widx_d  = widx_q;
    count_d = count_q;
    unique case (state_q)
      S_CNT: begin
        if (bypass) begin
          state_d = S_DONE;
        end else if (bv_q) begin
          // A zero count byte means a full RAM; the extra index bit keeps it distinct from 0.
          count_d = (shift_q == 8'd0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : (ADDR_WIDTH+1)'(shift_q);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bv_q) begin
          word_d[{bidx_q, 3'b000} +: 8] = shift_q;
          bidx_d = bidx_q + 1'b1;
          if (bidx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        widx_d  = widx_q + 1'b1;
        state_d = (widx_d == count_q) ? S_DONE : S_DATA;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_CNT;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    csb0_d     = (state_d != S_WRITE);
    web0_d     = (state_d != S_WRITE);
    wmask_d    = (state_d == S_WRITE) ? '1 : '0;
    addr_d     = (state_d == S_WRITE) ? widx_q[ADDR_WIDTH-1:0] : addr_q;
    din_d      = (state_d == S_WRITE) ? word_d : din_q;
    core_rst_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
  end

  assign sram.csb0   = csb0_q;
  assign sram.web0   = web0_q;
  assign sram.wmask0 = wmask_q;
  assign sram.addr0  = addr_q;
  assign sram.din0   = din_q;
  assign core_rst    = core_rst_q;
  assign load_done   = done_q;
  assign frame_err   = ferr_q;

endmodule
